// File: rtl/record_fifo_if.sv
// Word-in / record-out bundle between the half-record arbiter, record_fifo and its consumer.
// master = arbiter/consumer side, slave = the FIFO.
interface record_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [239:0] wrdata;
    logic         push;
    logic [479:0] rd_data;
    logic         rd_valid;
    logic         rd_ready;
    logic         full;
    logic [AW:0]  level;
    logic         overflow;

    modport master (
        output wrdata, push, rd_ready,
        input  rd_data, rd_valid, full, level, overflow
    );

    modport slave (
        input  wrdata, push, rd_ready,
        output rd_data, rd_valid, full, level, overflow
    );
endinterface

// File: rtl/record_fifo.sv
// Circular word buffer that re-pairs 240-bit words into 480-bit records behind a valid/ready output register.
// Pairs are always (even, odd) slots; a dropped push therefore misaligns later records.
module record_fifo #(
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    record_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [239:0]  mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [479:0]  rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;

    logic [AW:0]   level;
    logic          full;
    logic          wr_en;
    logic          load;
    logic [AW-1:0] ra0, ra1;

    always_comb begin
        level = wr_ptr_q - rd_ptr_q;
        // level never exceeds DEPTH, so its MSB alone means level == DEPTH
        full  = level[AW];
        wr_en = bus.push & ~full;
        load  = (|level[AW:1]) & (~rd_valid_q | bus.rd_ready);
        ra0   = rd_ptr_q[AW-1:0];
        ra1   = ra0 + 1'b1;

        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = load ? rd_ptr_q + 2'd2 : rd_ptr_q;
        rd_data_d  = load ? {mem_q[ra0], mem_q[ra1]} : rd_data_q;
        rd_valid_d = load | (rd_valid_q & ~bus.rd_ready);
        overflow_d = overflow_q | (bus.push & full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.wrdata;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.full     = full;
    assign bus.level    = level;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_record_fifo.sv
// Directed bench for record_fifo: vector table for basic pairing, hand sequences for full/overflow, wrap and reset.
module tb_record_fifo;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    record_fifo_if #(.DEPTH(DEPTH)) bus ();

    record_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
        $fatal(1);
    end

    function automatic logic [239:0] wd(input int i);
        logic [7:0] b;
        b = 8'(i + 17);
        return {16'(i), {28{b}}};
    endfunction

    task automatic check(input string nm, input logic [479:0] act, input logic [479:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%0h req=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic push;
        int   widx;
        logic rdy;
        logic ev;
        int   ea;
        int   eb;
        int   el;
    } vec_t;

    vec_t tbl [14];

    task automatic do_reset();
        rst = 1'b1;
        bus.push = 1'b0;
        bus.rd_ready = 1'b0;
        bus.wrdata = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.push = 1'b0;
        bus.rd_ready = 1'b0;
        bus.wrdata = '0;

        //            push widx rdy  ev  ea eb lvl
        tbl[0]  = '{1'b1, 0, 1'b1, 1'b0, 0, 0, 1};
        tbl[1]  = '{1'b1, 1, 1'b1, 1'b0, 0, 0, 2};
        tbl[2]  = '{1'b0, 0, 1'b1, 1'b1, 0, 1, 0};
        tbl[3]  = '{1'b0, 0, 1'b1, 1'b0, 0, 0, 0};
        tbl[4]  = '{1'b0, 0, 1'b1, 1'b0, 0, 0, 0};
        tbl[5]  = '{1'b1, 2, 1'b1, 1'b0, 0, 0, 1};
        tbl[6]  = '{1'b1, 3, 1'b1, 1'b0, 0, 0, 2};
        tbl[7]  = '{1'b1, 4, 1'b1, 1'b1, 2, 3, 1};
        tbl[8]  = '{1'b0, 0, 1'b1, 1'b0, 0, 0, 1};
        tbl[9]  = '{1'b0, 0, 1'b1, 1'b0, 0, 0, 1};
        tbl[10] = '{1'b1, 5, 1'b1, 1'b0, 0, 0, 2};
        tbl[11] = '{1'b0, 0, 1'b0, 1'b1, 4, 5, 0};
        tbl[12] = '{1'b0, 0, 1'b0, 1'b1, 4, 5, 0};
        tbl[13] = '{1'b0, 0, 1'b1, 1'b0, 0, 0, 0};

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_valid", 480'(bus.rd_valid), 480'(0));
        check("reset_data", bus.rd_data, 480'(0));
        check("reset_level", 480'(bus.level), 480'(0));
        check("reset_full", 480'(bus.full), 480'(0));
        check("reset_overflow", 480'(bus.overflow), 480'(0));

        // Table: basic pairing, odd word pending, push+load at level 2, hold.
        for (int v = 0; v < 14; v++) begin
            bus.push = tbl[v].push;
            bus.wrdata = wd(tbl[v].widx);
            bus.rd_ready = tbl[v].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_valid", v), 480'(bus.rd_valid), 480'(tbl[v].ev));
            check($sformatf("vec%0d_level", v), 480'(bus.level), 480'(tbl[v].el));
            check($sformatf("vec%0d_full", v), 480'(bus.full), 480'(0));
            check($sformatf("vec%0d_overflow", v), 480'(bus.overflow), 480'(0));
            if (tbl[v].ev)
                check($sformatf("vec%0d_data", v), bus.rd_data, {wd(tbl[v].ea), wd(tbl[v].eb)});
        end

        // Fill to full with output stalled, then overflow, then drain.
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus.push = 1'b1;
            bus.wrdata = wd(100 + i);
            @(negedge clk);
        end
        check("fill_full", 480'(bus.full), 480'(1));
        check("fill_level", 480'(bus.level), 480'(DEPTH));
        check("fill_valid", 480'(bus.rd_valid), 480'(1));
        check("fill_data", bus.rd_data, {wd(100), wd(101)});
        check("fill_overflow", 480'(bus.overflow), 480'(0));
        bus.wrdata = wd(100 + DEPTH + 2);
        @(negedge clk);
        check("drop_overflow", 480'(bus.overflow), 480'(1));
        check("drop_level", 480'(bus.level), 480'(DEPTH));
        check("drop_full", 480'(bus.full), 480'(1));
        bus.push = 1'b0;
        bus.rd_ready = 1'b1;
        for (int r = 1; r <= DEPTH / 2; r++) begin
            @(negedge clk);
            check($sformatf("drain%0d_valid", r), 480'(bus.rd_valid), 480'(1));
            check($sformatf("drain%0d_data", r), bus.rd_data, {wd(100 + 2 * r), wd(101 + 2 * r)});
            check($sformatf("drain%0d_level", r), 480'(bus.level), 480'(DEPTH - 2 * r));
            check($sformatf("drain%0d_full", r), 480'(bus.full), 480'(0));
        end
        @(negedge clk);
        check("drain_end_valid", 480'(bus.rd_valid), 480'(0));
        check("drain_end_overflow", 480'(bus.overflow), 480'(1));

        // Continuous push across pointer wrap with rd_ready toggling.
        do_reset();
        check("wrap_reset_overflow", 480'(bus.overflow), 480'(0));
        k = 0;
        for (int j = 0; j < 4 * DEPTH; j++) begin
            bus.push = 1'b1;
            bus.wrdata = wd(400 + j);
            bus.rd_ready = (j % 2 == 0);
            if (bus.rd_valid && bus.rd_ready) begin
                check($sformatf("wrap_rec%0d", k), bus.rd_data, {wd(400 + 2 * k), wd(401 + 2 * k)});
                k++;
            end
            @(negedge clk);
        end
        bus.push = 1'b0;
        bus.rd_ready = 1'b1;
        for (int c = 0; c < 60 && k < 2 * DEPTH; c++) begin
            if (bus.rd_valid) begin
                check($sformatf("wrap_rec%0d", k), bus.rd_data, {wd(400 + 2 * k), wd(401 + 2 * k)});
                k++;
            end
            @(negedge clk);
        end
        check("wrap_record_count", 480'(k), 480'(2 * DEPTH));
        check("wrap_overflow", 480'(bus.overflow), 480'(0));

        // Reset in the middle of a record with an odd word pending.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.push = 1'b1;
            bus.wrdata = wd(200 + i);
            @(negedge clk);
        end
        bus.push = 1'b0;
        check("pre_rst_valid", 480'(bus.rd_valid), 480'(1));
        check("pre_rst_level", 480'(bus.level), 480'(3));
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 480'(bus.rd_valid), 480'(0));
        check("mid_rst_level", 480'(bus.level), 480'(0));
        check("mid_rst_full", 480'(bus.full), 480'(0));
        check("mid_rst_overflow", 480'(bus.overflow), 480'(0));
        check("mid_rst_data", bus.rd_data, 480'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.rd_ready = 1'b1;
        bus.push = 1'b1;
        bus.wrdata = wd(300);
        @(negedge clk);
        bus.wrdata = wd(301);
        @(negedge clk);
        bus.push = 1'b0;
        check("post_rst_pending", 480'(bus.rd_valid), 480'(0));
        @(negedge clk);
        check("post_rst_valid", 480'(bus.rd_valid), 480'(1));
        check("post_rst_data", bus.rd_data, {wd(300), wd(301)});
        check("post_rst_level", 480'(bus.level), 480'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
